// File: rtl/carry_lookahead_adder_3op_pipe_pkg.sv
// Shared types and helpers for the pipelined three-operand adder.
// The CSA helper works per bit, so callers loop it over any operand width.
package adder_pkg;

    localparam int RES_EXTRA         = 2;
    localparam int DEFAULT_WIDTH     = 16;
    localparam int DEFAULT_RES_WIDTH = DEFAULT_WIDTH + RES_EXTRA;

    typedef struct packed {
        logic g;
        logic p;
    } cla_gp_t;

    // Returns {carry, sum} of a 3:2 compressor.
    function automatic logic [1:0] csa32(input logic a, input logic b, input logic c);
        return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
    endfunction

endpackage

// File: rtl/carry_lookahead_adder_3op_pipe_if.sv
// Operand/result handshake bundle for the three-operand adder.
interface carry_lookahead_adder_3op_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [WIDTH-1:0] in3;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout_1;
    logic             cout_2;

    modport master (
        output in_valid, in1, in2, in3, cin, out_ready,
        input  in_ready, out_valid, sum, cout_1, cout_2
    );

    modport slave (
        input  in_valid, in1, in2, in3, cin, out_ready,
        output in_ready, out_valid, sum, cout_1, cout_2
    );
endinterface

// File: rtl/carry_lookahead_adder_3op_pipe_cla.sv
// Combinational carry-lookahead adder: lookahead inside each CLA_BLOCK group,
// ripple of group carries between groups. A short last group is allowed.
module carry_lookahead_adder_nbits
    import adder_pkg::*;
#(
    parameter int WIDTH     = 18,
    parameter int CLA_BLOCK = 4
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o
);
    localparam int NG = (WIDTH + CLA_BLOCK - 1) / CLA_BLOCK;

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] c;
    logic [NG-1:0]    gcin;
    cla_gp_t          acc;

    always_comb begin
        g       = a_i & b_i;
        p       = a_i ^ b_i;
        c       = '0;
        gcin    = '0;
        gcin[0] = cin_i;
        acc     = '{g: 1'b0, p: 1'b1};
        for (int gi = 0; gi < NG; gi++) begin
            acc = '{g: 1'b0, p: 1'b1};
            for (int j = 0; j < CLA_BLOCK; j++) begin
                if (gi * CLA_BLOCK + j < WIDTH) begin
                    // acc holds the prefix G/P of the bits below this one in the group
                    c[gi*CLA_BLOCK+j] = acc.g | (acc.p & gcin[gi]);
                    acc.g = g[gi*CLA_BLOCK+j] | (p[gi*CLA_BLOCK+j] & acc.g);
                    acc.p = acc.p & p[gi*CLA_BLOCK+j];
                end
            end
            if (gi < NG - 1) begin
                gcin[gi+1] = acc.g | (acc.p & gcin[gi]);
            end
        end
        sum_o = p ^ c;
    end

endmodule

// File: rtl/carry_lookahead_adder_3op_pipe.sv
// Two-stage in1+in2+in3+cin adder: 3:2 CSA into S1, CLA into S2, valid/ready
// flow control at full throughput without a skid buffer.
module carry_lookahead_adder_3op_pipe
    import adder_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int CLA_BLOCK = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    carry_lookahead_adder_3op_pipe_if.slave bus
);
    localparam int RW = WIDTH + RES_EXTRA;

    logic             s1_adv;
    logic             s2_adv;
    logic             s1_valid_q;
    logic             s2_valid_q;
    logic [WIDTH-1:0] s1_s_d;
    logic [WIDTH-1:0] s1_c_d;
    logic [WIDTH-1:0] s1_s_q;
    logic [WIDTH-1:0] s1_c_q;
    logic             s1_cin_q;
    logic [RW-1:0]    res_d;
    logic [RW-1:0]    res_q;

    assign s2_adv       = !s2_valid_q || bus.out_ready;
    assign s1_adv       = !s1_valid_q || s2_adv;
    assign bus.in_ready = s1_adv;

    always_comb begin
        s1_s_d = '0;
        s1_c_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            {s1_c_d[i], s1_s_d[i]} = csa32(bus.in1[i], bus.in2[i], bus.in3[i]);
        end
    end

    // Carry vector has weight 2, so it enters the final adder shifted up one bit.
    carry_lookahead_adder_nbits #(
        .WIDTH     (RW),
        .CLA_BLOCK (CLA_BLOCK)
    ) u_cla (
        .a_i   ({2'b00, s1_s_q}),
        .b_i   ({1'b0, s1_c_q, 1'b0}),
        .cin_i (s1_cin_q),
        .sum_o (res_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_s_q     <= '0;
            s1_c_q     <= '0;
            s1_cin_q   <= 1'b0;
            res_q      <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_s_q   <= s1_s_d;
                    s1_c_q   <= s1_c_d;
                    s1_cin_q <= bus.cin;
                end
            end
            if (s2_adv) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    res_q <= res_d;
                end
            end
        end
    end

    assign bus.out_valid = s2_valid_q;
    assign bus.sum       = res_q[WIDTH-1:0];
    assign bus.cout_1    = res_q[WIDTH];
    assign bus.cout_2    = res_q[WIDTH+1];

endmodule

// File: tb/tb_carry_lookahead_adder_3op_pipe.sv
// Scoreboard bench for four adder configurations driven from shared stimulus.
module tb_carry_lookahead_adder_3op_pipe;
    localparam int ND = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid;
    logic        out_ready;
    logic        cin_r;
    logic [63:0] in1_r, in2_r, in3_r;
    logic        lat_chk;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    carry_lookahead_adder_3op_pipe_if #(.WIDTH(2))  if_a ();
    carry_lookahead_adder_3op_pipe_if #(.WIDTH(16)) if_b ();
    carry_lookahead_adder_3op_pipe_if #(.WIDTH(16)) if_c ();
    carry_lookahead_adder_3op_pipe_if #(.WIDTH(32)) if_d ();

    carry_lookahead_adder_3op_pipe #(.WIDTH(2),  .CLA_BLOCK(2)) dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
    carry_lookahead_adder_3op_pipe #(.WIDTH(16), .CLA_BLOCK(4)) dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));
    carry_lookahead_adder_3op_pipe #(.WIDTH(16), .CLA_BLOCK(2)) dut_c (.clk(clk), .rst(rst), .bus(if_c.slave));
    carry_lookahead_adder_3op_pipe #(.WIDTH(32), .CLA_BLOCK(4)) dut_d (.clk(clk), .rst(rst), .bus(if_d.slave));

    assign if_a.in_valid = in_valid;  assign if_a.out_ready = out_ready;  assign if_a.cin = cin_r;
    assign if_b.in_valid = in_valid;  assign if_b.out_ready = out_ready;  assign if_b.cin = cin_r;
    assign if_c.in_valid = in_valid;  assign if_c.out_ready = out_ready;  assign if_c.cin = cin_r;
    assign if_d.in_valid = in_valid;  assign if_d.out_ready = out_ready;  assign if_d.cin = cin_r;
    assign if_a.in1 = in1_r[1:0];   assign if_a.in2 = in2_r[1:0];   assign if_a.in3 = in3_r[1:0];
    assign if_b.in1 = in1_r[15:0];  assign if_b.in2 = in2_r[15:0];  assign if_b.in3 = in3_r[15:0];
    assign if_c.in1 = in1_r[15:0];  assign if_c.in2 = in2_r[15:0];  assign if_c.in3 = in3_r[15:0];
    assign if_d.in1 = in1_r[31:0];  assign if_d.in2 = in2_r[31:0];  assign if_d.in3 = in3_r[31:0];

    logic        ov[ND];
    logic        ir[ND];
    logic [65:0] res[ND];
    int          wid[ND] = '{2, 16, 16, 32};

    assign ov[0] = if_a.out_valid;  assign ir[0] = if_a.in_ready;
    assign ov[1] = if_b.out_valid;  assign ir[1] = if_b.in_ready;
    assign ov[2] = if_c.out_valid;  assign ir[2] = if_c.in_ready;
    assign ov[3] = if_d.out_valid;  assign ir[3] = if_d.in_ready;
    assign res[0] = 66'({if_a.cout_2, if_a.cout_1, if_a.sum});
    assign res[1] = 66'({if_b.cout_2, if_b.cout_1, if_b.sum});
    assign res[2] = 66'({if_c.cout_2, if_c.cout_1, if_c.sum});
    assign res[3] = 66'({if_d.cout_2, if_d.cout_1, if_d.sum});

    typedef struct {
        logic [65:0] r;
        int          cyc;
    } sb_t;

    sb_t q[ND][$];
    bit  held[ND];

    task automatic chk(input string tag, input logic [65:0] got, input logic [65:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [65:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                          input logic [63:0] c, input logic ci);
        logic [65:0] m;
        m = (66'd1 << w) - 66'd1;
        return (66'(a) & m) + (66'(b) & m) + (66'(c) & m) + 66'(ci);
    endfunction

    function automatic logic [63:0] rnd_op();
        case ($urandom_range(0, 7))
            0:       return 64'h0;
            1:       return 64'hFFFF_FFFF_FFFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    function automatic int q_total();
        int t = 0;
        for (int k = 0; k < ND; k++) t += q[k].size();
        return t;
    endfunction

    // Handshakes are judged at negedge; inputs only change just after posedge.
    always @(negedge clk) begin
        for (int k = 0; k < ND; k++) begin
            if (rst) begin
                q[k].delete();
                held[k] = 1'b0;
            end else begin
                if (held[k]) chk($sformatf("stall_valid%0d", k), 66'(ov[k]), 66'd1);
                if (ov[k]) begin
                    if (q[k].size() == 0) begin
                        chk($sformatf("spurious%0d", k), 66'(ov[k]), 66'd0);
                    end else begin
                        chk($sformatf("data%0d", k), res[k], q[k][0].r);
                        if (out_ready) begin
                            if (lat_chk) chk($sformatf("latency%0d", k), 66'(cyc - q[k][0].cyc), 66'd2);
                            void'(q[k].pop_front());
                        end
                    end
                end
                held[k] = ov[k] && !out_ready;
                if (in_valid && ir[k])
                    q[k].push_back('{r: model(wid[k], in1_r, in2_r, in3_r, cin_r), cyc: cyc});
            end
        end
    end

    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c, input logic ci);
        int n = 0;
        in_valid = 1'b1;
        in1_r = a;  in2_r = b;  in3_r = c;  cin_r = ci;
        @(negedge clk);
        while (!if_b.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("send_timeout", 66'(n), 66'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while (q_total() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("drain_timeout", 66'(q_total()), 66'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cin_r     = 1'b0;
        in1_r = '0;  in2_r = '0;  in3_r = '0;
        lat_chk   = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < ND; k++) begin
            chk($sformatf("rst_valid%0d", k), 66'(ov[k]), 66'd0);
            chk($sformatf("rst_res%0d", k), res[k], 66'd0);
            chk($sformatf("rst_ready%0d", k), 66'(ir[k]), 66'd1);
        end
        @(posedge clk);
        #1;

        // Directed vectors, back-to-back with the output always ready
        send(64'd1, 64'd0, 64'd1, 1'b0);
        send(64'd2, 64'd3, 64'd1, 1'b0);
        send(64'd1, 64'd2, 64'd1, 1'b1);
        send(64'd3, 64'd3, 64'd3, 1'b1);
        send('1, '1, '1, 1'b1);
        send('0, '0, '0, 1'b0);
        drain();
        lat_chk = 1'b0;

        // Stall with four sets queued behind a blocked output
        out_ready = 1'b0;
        fork
            repeat (4) send(rnd_op(), rnd_op(), rnd_op(), 1'($urandom_range(0, 1)));
            begin
                repeat (5) @(negedge clk);
                for (int k = 0; k < ND; k++) begin
                    chk($sformatf("stall_ready%0d", k), 66'(ir[k]), 66'd0);
                    chk($sformatf("stall_out%0d", k), 66'(ov[k]), 66'd1);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Random bubbles on both sides
        fork
            repeat (1000) begin
                @(posedge clk);
                #1 out_ready = 1'($urandom_range(0, 1));
            end
            repeat (350) begin
                if ($urandom_range(0, 2) == 0) begin
                    in1_r = rnd_op();  in2_r = rnd_op();  in3_r = rnd_op();
                    @(posedge clk);
                    #1;
                end else begin
                    send(rnd_op(), rnd_op(), rnd_op(), 1'($urandom_range(0, 1)));
                end
            end
        join
        drain();

        // Reset with two sets in flight
        out_ready = 1'b0;
        send(rnd_op(), rnd_op(), rnd_op(), 1'b1);
        send(rnd_op(), rnd_op(), rnd_op(), 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < ND; k++) begin
            chk($sformatf("flush_valid%0d", k), 66'(ov[k]), 66'd0);
            chk($sformatf("flush_res%0d", k), res[k], 66'd0);
            chk($sformatf("flush_ready%0d", k), 66'(ir[k]), 66'd1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;

        // Long random run with occasional backpressure
        fork
            repeat (12000) begin
                @(posedge clk);
                #1 out_ready = ($urandom_range(0, 7) != 0);
            end
            repeat (10000) send(rnd_op(), rnd_op(), rnd_op(), 1'($urandom_range(0, 1)));
        join
        drain();

        for (int k = 0; k < ND; k++)
            chk($sformatf("leftover%0d", k), 66'(q[k].size()), 66'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
